// File: rtl/apb_controller_if.sv
// Bus bundle between the AHB slave interface, the bridge FSM and the APB interface stage.
// The master modport is the driving side (AHB slave interface / APB stage); slave is the FSM.
interface apb_controller_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned SLAVES = 3
);
  logic              valid;
  logic [WIDTH-1:0]  Haddr;
  logic [WIDTH-1:0]  Haddr_d;
  logic [WIDTH-1:0]  Hwdata;
  logic              Hwrite;
  logic              Hwrite_d;
  logic [SLAVES-1:0] Hselx;
  logic [SLAVES-1:0] Hselx_d;
  logic [WIDTH-1:0]  Paddr_out;
  logic [WIDTH-1:0]  Pwdata_out;
  logic              Pwrite_out;
  logic              Penable_out;
  logic [SLAVES-1:0] Pselx_out;
  logic              Hreadyout;

  modport master (
    output valid, Haddr, Haddr_d, Hwdata, Hwrite, Hwrite_d, Hselx, Hselx_d,
    input  Paddr_out, Pwdata_out, Pwrite_out, Penable_out, Pselx_out, Hreadyout
  );

  modport slave (
    input  valid, Haddr, Haddr_d, Hwdata, Hwrite, Hwrite_d, Hselx, Hselx_d,
    output Paddr_out, Pwdata_out, Pwrite_out, Penable_out, Pselx_out, Hreadyout
  );
endinterface

// File: rtl/apb_controller.sv
// AHB-to-APB bridge FSM: sequences APB SETUP/ENABLE phases and throttles AHB via Hreadyout.
// All outputs are registered; loads happen on entry to each state.
module apb_controller #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned SLAVES = 3
) (
  input logic             Hclk,
  input logic             Hreset,
  apb_controller_if.slave bus_io
);

  typedef enum logic [2:0] {
    StIdle, StWwait, StRead, StWrite, StWritep, StRenable, StWenable, StWenablep
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  paddr_q, paddr_d;
  logic [WIDTH-1:0]  pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic              penable_q, penable_d;
  logic [SLAVES-1:0] pselx_q, pselx_d;
  logic              hready_q, hready_d;

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    penable_d = penable_q;
    pselx_d   = pselx_q;
    hready_d  = hready_q;

    unique case (state_q)
      StIdle: begin
        if (bus_io.valid) state_d = bus_io.Hwrite ? StWwait : StRead;
      end
      StWwait:  state_d = bus_io.valid ? StWritep : StWrite;
      StRead:   state_d = StRenable;
      StWrite:  state_d = bus_io.valid ? StWenablep : StWenable;
      StWritep: state_d = StWenablep;
      StRenable, StWenable: begin
        if (!bus_io.valid)      state_d = StIdle;
        else if (bus_io.Hwrite) state_d = StWwait;
        else                    state_d = StRead;
      end
      StWenablep: begin
        if (!bus_io.Hwrite_d)  state_d = StRead;
        else if (bus_io.valid) state_d = StWritep;
        else                   state_d = StWrite;
      end
    endcase

    unique case (state_d)
      StRead: begin
        // After a pipelined write the pending read was captured one cycle earlier.
        if (state_q == StWenablep) begin
          paddr_d = bus_io.Haddr_d;
          pselx_d = bus_io.Hselx_d;
        end else begin
          paddr_d = bus_io.Haddr;
          pselx_d = bus_io.Hselx;
        end
        pwrite_d  = 1'b0;
        penable_d = 1'b0;
        hready_d  = 1'b0;
      end
      StWrite, StWritep: begin
        paddr_d   = bus_io.Haddr_d;
        pwdata_d  = bus_io.Hwdata;
        pwrite_d  = 1'b1;
        pselx_d   = bus_io.Hselx_d;
        penable_d = 1'b0;
        hready_d  = 1'b0;
      end
      StRenable, StWenable, StWenablep: begin
        penable_d = 1'b1;
        hready_d  = 1'b1;
      end
      StIdle, StWwait: begin
        pselx_d   = '0;
        penable_d = 1'b0;
        hready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q   <= StIdle;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
      pselx_q   <= '0;
      hready_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      penable_q <= penable_d;
      pselx_q   <= pselx_d;
      hready_q  <= hready_d;
    end
  end

  assign bus_io.Paddr_out   = paddr_q;
  assign bus_io.Pwdata_out  = pwdata_q;
  assign bus_io.Pwrite_out  = pwrite_q;
  assign bus_io.Penable_out = penable_q;
  assign bus_io.Pselx_out   = pselx_q;
  assign bus_io.Hreadyout   = hready_q;

endmodule
